// File: rtl/mips_cpu_register_file_sb.sv
// Parametrised multi-read register file with an early (ALU) and a late (load/muldiv)
// write port, plus a per-register pending scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.

module mips_cpu_register_file_sb_rd #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]                 pending,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                             wr_c_en,
  input  logic [ADDR_WIDTH-1:0]            wr_c_addr,
  input  logic [DATA_WIDTH-1:0]            wr_c_data,
  input  logic                             wr_d_en,
  input  logic [ADDR_WIDTH-1:0]            wr_d_addr,
  input  logic [DATA_WIDTH-1:0]            wr_d_data,
`endif
  output logic [DATA_WIDTH-1:0]            data,
  output logic                             busy
);
  always_comb begin
    data = '0;
    busy = 1'b0;
    if (!reset && addr != '0) begin
      data = regs[addr];
      busy = pending[addr];
`ifdef REGFILE_BYPASS_EN
      // Port c is the younger instruction, so it shadows port d.
      if (wr_c_en && wr_c_addr == addr)      data = wr_c_data;
      else if (wr_d_en && wr_d_addr == addr) data = wr_d_data;
      if (wr_d_en && wr_d_addr == addr)      busy = 1'b0;
`endif
    end
  end
endmodule

module mips_cpu_register_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_enable,
  output logic [DATA_WIDTH-1:0]          register_v0,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ-1:0]            read_busy,
  input  logic [ADDR_WIDTH-1:0]          write_addr_c,
  input  logic                           write_enable_c,
  input  logic [DATA_WIDTH-1:0]          write_data_c,
  input  logic [ADDR_WIDTH-1:0]          write_addr_d,
  input  logic                           write_enable_d,
  input  logic [DATA_WIDTH-1:0]          write_data_d,
  input  logic                           issue_valid,
  input  logic [ADDR_WIDTH-1:0]          issue_addr,
  output logic                           issue_accept,
  output logic [CNT_WIDTH-1:0]           pending_count
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
  logic [DEPTH-1:0]                 pending, pending_next;
  logic [CNT_WIDTH-1:0]             count_next;
  logic                             wc_en, wd_en, set, clr;

  // Effective write strobes: live cycle, nonzero destination.
  assign wc_en = write_enable_c & clk_enable & ~reset & (write_addr_c != '0);
  assign wd_en = write_enable_d & clk_enable & ~reset & (write_addr_d != '0);

  assign issue_accept = issue_valid & clk_enable & ~reset &
                        ((issue_addr == '0) | ~pending[issue_addr]);
  assign set = issue_accept & (issue_addr != '0);
  assign clr = wd_en;

  // Clear first, then set, so a same-address issue leaves a fresh reservation.
  always_comb begin
    pending_next = pending;
    if (clr) pending_next[write_addr_d] = 1'b0;
    if (set) pending_next[issue_addr]   = 1'b1;
    count_next = pending_count + CNT_WIDTH'(set)
               - CNT_WIDTH'(clr & pending[write_addr_d]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs          <= '0;
      pending       <= '0;
      pending_count <= '0;
    end else if (clk_enable) begin
      if (wd_en) regs[write_addr_d] <= write_data_d;
      if (wc_en) regs[write_addr_c] <= write_data_c;
      pending       <= pending_next;
      pending_count <= count_next;
    end
  end

  assign register_v0 = reset ? '0 : regs[2];

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    mips_cpu_register_file_sb_rd #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)
    ) u_rd (
      .regs     (regs),
      .pending  (pending),
      .reset    (reset),
      .addr     (read_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
`ifdef REGFILE_BYPASS_EN
      .wr_c_en  (wc_en),
      .wr_c_addr(write_addr_c),
      .wr_c_data(write_data_c),
      .wr_d_en  (wd_en),
      .wr_d_addr(write_addr_d),
      .wr_d_data(write_data_d),
`endif
      .data     (read_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .busy     (read_busy[k])
    );
  end
endmodule

// File: doc/mips_cpu_register_file_sb.md
Name: mips_cpu_register_file_sb

Overview:
- Parametrised successor to the CPU's 2R/1W register file, sized for the multicycle/pipelined datapath.
- Generalised width, depth and read-port count.
- Adds a second, late write port for load and mul/div writeback.
- Adds a per-register pending scoreboard so the controller can detect RAW hazards on long-latency results.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH; register 0 hardwired to zero
- NUM_READ, 2, number of combinational read ports (1..4)
- CNT_WIDTH, ADDR_WIDTH+1, width of the pending-count output

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- clk_enable  in  1  global stall; when low, no state changes
- register_v0  out  DATA_WIDTH  contents of register 2 (debug/testbench)
- read_addr  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- read_data  out  NUM_READ*DATA_WIDTH  packed read data, same packing
- read_busy  out  NUM_READ  port k's addressed register has a pending result
- write_addr_c  in  ADDR_WIDTH  early (ALU) write address
- write_enable_c  in  1  early write strobe
- write_data_c  in  DATA_WIDTH  early write data
- write_addr_d  in  ADDR_WIDTH  late (load/muldiv) write address
- write_enable_d  in  1  late write strobe; also clears pending bit
- write_data_d  in  DATA_WIDTH  late write data
- issue_valid  in  1  long-latency op requests to reserve a destination
- issue_addr  in  ADDR_WIDTH  destination to reserve
- issue_accept  out  1  reservation taken this cycle
- pending_count  out  CNT_WIDTH  number of registers currently pending

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset (rising edge with reset=1): all registers, pending bits and pending_count go to 0; clk_enable is ignored.
- While reset is high: read_data, read_busy, register_v0 and issue_accept read 0.
- Reads are combinational:
  - read_data port k = regs[addr_k];
  - address 0 always returns 0 and read_busy=0.
- Writes (clk_enable=1, reset=0), on the rising edge:
  - port c writes if write_enable_c and write_addr_c != 0;
  - port d writes if write_enable_d and write_addr_d != 0;
  - writes to register 0 are discarded.
- Same-address collision, both write enables high: port c wins. It is the younger instruction in program order.
- Scoreboard, one pending bit per register:
  - issue_accept = issue_valid & clk_enable & !reset & (issue_addr==0 | !pending[issue_addr]).
  - An accepted issue to a nonzero address sets its pending bit next edge.
  - An issue to address 0 is accepted with no state change.
  - An issue to an already-pending register is refused (issue_accept=0) with no state change; the controller stalls.
  - write_enable_d clears pending[write_addr_d] next edge.
- Simultaneous issue and late write to the same address: the write lands and the bit ends set (new reservation). issue_accept is evaluated on the pre-edge pending state, so it is refused if the bit was set.
- Port c writes never touch pending bits.
- Late write to a non-pending register: data is written; pending is unchanged; not an error.
- pending_count:
  - registered; +1 on set, -1 on clear, net 0 when both occur on different addresses;
  - always equals popcount(pending);
  - range 0..2**ADDR_WIDTH-1, no wrap possible.
- clk_enable=0: registers, pending bits and count hold; reads remain live.
- Reset asserted mid-operation (pending bits set) discards all reservations; the next cycle shows pending_count=0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - read port k forwards same-cycle write data when its address matches an enabled nonzero write, with port c taking priority over port d;
  - read_busy for an address receiving a port-d write this cycle reads 0.
- Undefined: reads return the stored value only; the new value is visible the cycle after the write edge.

Test Plan:
- Reset then read all addrs on every port -> all read_data=0, read_busy=0, pending_count=0, register_v0=0.
- Port c write 0xDEADBEEF to r2, then write 0x1234 to r0 -> register_v0=0xDEADBEEF; read r0 = 0.
- Issue r5 (accept=1), re-issue r5 (accept=0), read r5 -> read_busy=1, count=1; port d write 0x55 to r5 -> next cycle busy=0, data=0x55, count=0.
- Same edge: port c and port d both write r7 (0xAAAA vs 0xBBBB) -> r7=0xAAAA; with clk_enable=0, writes to r8 are ignored and r8 stays 0.
- Issue r9 and late-write r9 on the same edge while r9 not pending -> r9 holds data, pending set, count=1; assert reset -> count=0, all busy=0.
- REGFILE_BYPASS_EN: write r3=0x77 on port c and read r3 in the same cycle -> read_data=0x77 before the edge; without the macro -> old value.
